// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, bus width constants, owner index type.
package wb_pkg;

   localparam int DAT_W = 32;
   localparam int SEL_W = 4;

   // One-hot so each output decode is a single state bit.
   typedef enum logic [2:0] {
      IDLE    = 3'b001,
      GRANT   = 3'b010,
      RELEASE = 3'b100
   } state_t;

   // Index of the master that owns (or last owned) the slave bus.
   // 0 = m0 (instruction fetch), 1 = m1 (data).
   typedef logic owner_t;

   localparam owner_t OWN_M0 = 1'b0;
   localparam owner_t OWN_M1 = 1'b1;

endpackage

// File: rtl/wb_rr_arb.sv
// Two-input round-robin pick: on a tie the master that did not own last wins.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when to act on the pick.
// Ports: req0/req1 = requests, last_owner = previous owner,
//        valid = any request present, winner = chosen master index.
module wb_rr_arb
   import wb_pkg::*;
(
   input  logic   req0,
   input  logic   req1,
   input  owner_t last_owner,
   output logic   valid,
   output owner_t winner
);

   always_comb begin
      valid  = req0 | req1;
      winner = OWN_M0;
      if (req0 && req1) begin
         winner = owner_t'(~last_owner);
      end else if (req1) begin
         winner = OWN_M1;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone arbiter with round-robin tie break and a transfer timeout.
// Latency: request to s_cyc_o is 1 cycle; slave ack/err reach the owner in the same cycle.
// Backpressure: a granted transfer holds the bus until ack/err, timeout or owner drop; no preemption.
// Ports: clk_i/rst_i (sync, active-low); m0_*/m1_* master request, write data and terminations;
//        s_* slave-side cycle/strobe/address/data/select and returned data/ack/err.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int ADR_W   = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,

   input  logic             m0_cyc_i,
   input  logic             m0_stb_i,
   input  logic             m0_we_i,
   input  logic [ADR_W-1:0] m0_adr_i,
   input  logic [DAT_W-1:0] m0_dat_i,
   input  logic [SEL_W-1:0] m0_sel_i,
   output logic [DAT_W-1:0] m0_dat_o,
   output logic             m0_ack_o,
   output logic             m0_err_o,

   input  logic             m1_cyc_i,
   input  logic             m1_stb_i,
   input  logic             m1_we_i,
   input  logic [ADR_W-1:0] m1_adr_i,
   input  logic [DAT_W-1:0] m1_dat_i,
   input  logic [SEL_W-1:0] m1_sel_i,
   output logic [DAT_W-1:0] m1_dat_o,
   output logic             m1_ack_o,
   output logic             m1_err_o,

   output logic             s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic [ADR_W-1:0] s_adr_o,
   output logic [DAT_W-1:0] s_dat_o,
   output logic [SEL_W-1:0] s_sel_o,
   input  logic [DAT_W-1:0] s_dat_i,
   input  logic             s_ack_i,
   input  logic             s_err_i
);

   localparam int              CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   owner_t           owner_q, owner_d;
   owner_t           last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic   req0, req1;
   logic   pick_vld;
   owner_t pick;

   logic in_grant;
   logic own_cyc;
   logic tmo_hit;
   logic fwd_ack;
   logic fwd_err;

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;

   wb_rr_arb u_rr (
      .req0       (req0),
      .req1       (req1),
      .last_owner (last_q),
      .valid      (pick_vld),
      .winner     (pick)
   );

   assign in_grant = (state_q == GRANT);
   assign own_cyc  = (owner_q == OWN_M1) ? m1_cyc_i : m0_cyc_i;
   assign tmo_hit  = (cnt_q == TMO_LAST);

   // Owner dropping cyc (kill) masks every termination, even one arriving
   // in the same cycle. A real slave ack/err always beats the timeout.
   assign fwd_ack = in_grant & own_cyc & s_ack_i;
   assign fwd_err = in_grant & own_cyc & (s_err_i | (tmo_hit & ~s_ack_i));

   // Next-state logic
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               owner_d = pick;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (!own_cyc) begin
               // Killed transfer does not count as a turn for round-robin.
               state_d = IDLE;
            end else if (s_ack_i || s_err_i || tmo_hit) begin
               last_d  = owner_q;
               state_d = RELEASE;
            end else begin
               // Exit at TMO_LAST guarantees the counter never wraps here.
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         owner_q <= OWN_M0;
         last_q  <= OWN_M1;  // m0 wins the first tie after reset
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Bus strobes come straight from the registered state so they are glitch-free.
   assign s_cyc_o = in_grant;
   assign s_stb_o = in_grant;

   // Slave-side request mux follows the owner combinationally.
   always_comb begin
      if (owner_q == OWN_M1) begin
         s_we_o  = m1_we_i;
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
         s_sel_o = m1_sel_i;
      end else begin
         s_we_o  = m0_we_i;
         s_adr_o = m0_adr_i;
         s_dat_o = m0_dat_i;
         s_sel_o = m0_sel_i;
      end
   end

   // Read data is broadcast; only the owner's ack qualifies it.
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   assign m0_ack_o = fwd_ack & (owner_q == OWN_M0);
   assign m0_err_o = fwd_err & (owner_q == OWN_M0);
   assign m1_ack_o = fwd_ack & (owner_q == OWN_M1);
   assign m1_err_o = fwd_err & (owner_q == OWN_M1);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: transfer-level model checked every cycle plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_arbiter;

   localparam int TO = 16;
   localparam int AW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_i = 1'b0;
   logic          m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
   logic [AW-1:0] m0_adr_i = '0;
   logic [31:0]   m0_dat_i = '0;
   logic [3:0]    m0_sel_i = '0;
   logic [31:0]   m0_dat_o;
   logic          m0_ack_o, m0_err_o;
   logic          m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
   logic [AW-1:0] m1_adr_i = '0;
   logic [31:0]   m1_dat_i = '0;
   logic [3:0]    m1_sel_i = '0;
   logic [31:0]   m1_dat_o;
   logic          m1_ack_o, m1_err_o;
   logic          s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0] s_adr_o;
   logic [31:0]   s_dat_o;
   logic [3:0]    s_sel_o;
   logic [31:0]   s_dat_i = '0;
   logic          s_ack_i = 1'b0;
   logic          s_err_i = 1'b0;

   wb_arbiter #(.TIMEOUT(TO), .ADR_W(AW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
      .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
      .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
      .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_err_i(s_err_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- slave responder ----------------
   int          gcnt   = 0;   // consecutive cycles s_cyc_o has been high
   int          ack_at = 0;   // respond with ack in this grant cycle (0 = never)
   int          err_at = 0;   // respond with err in this grant cycle (0 = never)
   logic [31:0] rdata  = '0;

   always begin
      @(posedge clk);
      #1;
      if (s_cyc_o === 1'b1) gcnt++;
      else gcnt = 0;
      s_ack_i = (ack_at != 0) && (gcnt == ack_at);
      s_err_i = (err_at != 0) && (gcnt == err_at);
      s_dat_i = s_ack_i ? rdata : (32'h5A5A_0000 + 32'(gcnt));
   end

   // ---------------- transfer-level model ----------------
   // owner = -1 when the bus is free; age = 1-based index of the current grant cycle;
   // gap = the mandatory quiet cycle after a completed transfer.
   int mdl_owner = -1;
   int mdl_last  = 1;
   int mdl_age   = 0;
   bit mdl_gap   = 0;
   bit chk_en    = 0;

   always @(posedge clk) begin
      bit r0, r1, ocyc;
      r0 = m0_cyc_i && m0_stb_i;
      r1 = m1_cyc_i && m1_stb_i;
      if (!rst_i) begin
         mdl_owner = -1; mdl_last = 1; mdl_age = 0; mdl_gap = 0;
      end else if (mdl_gap) begin
         mdl_gap = 0;
      end else if (mdl_owner < 0) begin
         if (r0 && r1) mdl_owner = 1 - mdl_last;
         else if (r0)  mdl_owner = 0;
         else if (r1)  mdl_owner = 1;
         mdl_age = 1;
      end else begin
         ocyc = (mdl_owner == 1) ? m1_cyc_i : m0_cyc_i;
         if (!ocyc) begin
            mdl_owner = -1;
         end else if (s_ack_i || s_err_i || mdl_age == TO) begin
            mdl_last  = mdl_owner;
            mdl_owner = -1;
            mdl_gap   = 1;
         end else begin
            mdl_age++;
         end
      end
      chk_en = 1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      bit granted, ocyc, eack, eerr;
      if (chk_en) begin
         granted = (mdl_owner >= 0);
         ocyc    = granted && ((mdl_owner == 1) ? m1_cyc_i : m0_cyc_i);
         eack    = ocyc && s_ack_i;
         eerr    = ocyc && (s_err_i || (mdl_age == TO && !s_ack_i));
         chk("s_cyc", 32'(s_cyc_o), 32'(granted));
         chk("s_stb", 32'(s_stb_o), 32'(granted));
         chk("m0_ack", 32'(m0_ack_o), 32'(eack && mdl_owner == 0));
         chk("m0_err", 32'(m0_err_o), 32'(eerr && mdl_owner == 0));
         chk("m1_ack", 32'(m1_ack_o), 32'(eack && mdl_owner == 1));
         chk("m1_err", 32'(m1_err_o), 32'(eerr && mdl_owner == 1));
         chk("m0_dat_o", m0_dat_o, s_dat_i);
         chk("m1_dat_o", m1_dat_o, s_dat_i);
         if (granted) begin
            chk("s_adr", s_adr_o, (mdl_owner == 1) ? m1_adr_i : m0_adr_i);
            chk("s_dat", s_dat_o, (mdl_owner == 1) ? m1_dat_i : m0_dat_i);
            chk("s_sel", 32'(s_sel_o), 32'((mdl_owner == 1) ? m1_sel_i : m0_sel_i));
            chk("s_we", 32'(s_we_o), 32'((mdl_owner == 1) ? m1_we_i : m0_we_i));
         end
      end
   end

   // ---------------- event monitor for directed checks ----------------
   int          grant_idx = 0, low_run = 0, cyc_hi_cnt = 0;
   int          ack0_cnt = 0, ack1_cnt = 0, err0_cnt = 0, err1_cnt = 0;
   int          ack0_idx = 0, err0_idx = 0;
   logic [31:0] dat0 = '0;
   bit          prev_cyc = 0;
   logic [31:0] grant_q[$];
   int          gap_q[$];

   always @(negedge clk) begin
      if (s_cyc_o === 1'b1) begin
         if (!prev_cyc) begin
            grant_q.push_back(s_adr_o);
            gap_q.push_back(low_run);
            grant_idx = 0;
         end
         grant_idx++;
         cyc_hi_cnt++;
         low_run = 0;
      end else begin
         grant_idx = 0;
         low_run++;
      end
      prev_cyc = (s_cyc_o === 1'b1);
      if (m0_ack_o === 1'b1) begin ack0_cnt++; ack0_idx = grant_idx; dat0 = m0_dat_o; end
      if (m0_err_o === 1'b1) begin err0_cnt++; err0_idx = grant_idx; end
      if (m1_ack_o === 1'b1) ack1_cnt++;
      if (m1_err_o === 1'b1) err1_cnt++;
   end

   function automatic void clear_mon();
      low_run = 0; cyc_hi_cnt = 0;
      ack0_cnt = 0; ack1_cnt = 0; err0_cnt = 0; err1_cnt = 0;
      ack0_idx = 0; err0_idx = 0; dat0 = '0;
      grant_q.delete(); gap_q.delete();
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_masters();
      m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
      m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      idle_masters();
      ack_at = 0; err_at = 0;
      tick(); tick();
      rst_i = 1'b1;
      tick();
      clear_mon();
   endtask

   task automatic wait_gcnt(input int n, input string what);
      for (int k = 0; k < 60 && gcnt != n; k++) tick();
      chk(what, 32'(gcnt), 32'(n));
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // ---- reset state ----
      tick(); tick();
      @(negedge clk);
      chk("rst_s_cyc", 32'(s_cyc_o), 0);
      chk("rst_acks", 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 0);

      // ---- m0 single read, ack in 2nd grant cycle ----
      do_reset();
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100; m0_sel_i = 4'hF;
      ack_at = 2; rdata = 32'hDEADBEEF;
      for (int k = 0; k < 20 && ack0_cnt == 0; k++) tick();
      idle_masters();
      tick(); tick(); tick();
      chk("t1_cyc_cycles", 32'(cyc_hi_cnt), 2);
      chk("t1_ack0_cnt", 32'(ack0_cnt), 1);
      chk("t1_ack0_idx", 32'(ack0_idx), 2);
      chk("t1_dat0", dat0, 32'hDEADBEEF);
      chk("t1_ack1_cnt", 32'(ack1_cnt), 0);
      chk("t1_adr", (grant_q.size() > 0) ? grant_q[0] : 32'hFFFF_FFFF, 32'h100);

      // ---- both masters continuously requesting from reset release ----
      rst_i = 0; ack_at = 1;
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'hA0;
      m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'hB0; m1_we_i = 0;
      tick(); tick();
      rst_i = 1;
      clear_mon();
      for (int k = 0; k < 40 && grant_q.size() < 4; k++) tick();
      idle_masters();
      chk("t2_grants", 32'(grant_q.size()), 4);
      if (grant_q.size() >= 4) begin
         chk("t2_order0", grant_q[0], 32'hA0);
         chk("t2_order1", grant_q[1], 32'hB0);
         chk("t2_order2", grant_q[2], 32'hA0);
         chk("t2_order3", grant_q[3], 32'hB0);
         chk("t2_first_latency", 32'(gap_q[0]), 1);
         chk("t2_gap1", 32'(gap_q[1]), 2);
         chk("t2_gap3", 32'(gap_q[3]), 2);
      end
      chk("t2_ack0", 32'(ack0_cnt), 2);
      chk("t2_ack1", 32'(ack1_cnt), 2);
      tick(); tick();

      // ---- m1 write killed in 3rd grant cycle ----
      do_reset();
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1;
      m1_adr_i = 32'h2000; m1_dat_i = 32'hCAFEF00D; m1_sel_i = 4'b0011;
      wait_gcnt(3, "t3_wait_grant3");
      m1_cyc_i = 0; m1_stb_i = 0;
      tick();
      @(negedge clk);
      chk("t3_cyc_after_kill", 32'(s_cyc_o), 0);
      chk("t3_cyc_cycles", 32'(cyc_hi_cnt), 3);
      chk("t3_m1_ack", 32'(ack1_cnt), 0);
      chk("t3_m1_err", 32'(err1_cnt), 0);
      clear_mon();
      ack_at = 1;
      m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_adr_i = 32'hA0;
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'hB0;
      for (int k = 0; k < 20 && grant_q.size() < 1; k++) tick();
      idle_masters();
      chk("t3_tie_winner", (grant_q.size() > 0) ? grant_q[0] : 32'hFFFF_FFFF, 32'hA0);
      tick(); tick();

      // ---- timeout: slave never answers ----
      do_reset();
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h300;
      for (int k = 0; k < 40 && err0_cnt == 0; k++) tick();
      idle_masters();
      @(negedge clk);
      chk("t4_cyc_after_tmo", 32'(s_cyc_o), 0);
      chk("t4_err0_idx", 32'(err0_idx), 16);
      chk("t4_err0_cnt", 32'(err0_cnt), 1);
      chk("t4_ack0_cnt", 32'(ack0_cnt), 0);
      chk("t4_cyc_cycles", 32'(cyc_hi_cnt), 16);
      tick(); tick();

      // ---- ack arrives exactly at the timeout cycle ----
      do_reset();
      ack_at = 16; rdata = 32'h12345678;
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h400;
      for (int k = 0; k < 40 && ack0_cnt == 0 && err0_cnt == 0; k++) tick();
      idle_masters();
      tick(); tick();
      chk("t5_ack0_cnt", 32'(ack0_cnt), 1);
      chk("t5_ack0_idx", 32'(ack0_idx), 16);
      chk("t5_err0_cnt", 32'(err0_cnt), 0);
      chk("t5_dat0", dat0, 32'h12345678);

      // ---- reset during grant ----
      do_reset();
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h500;
      wait_gcnt(2, "t6_wait_grant2");
      rst_i = 0;
      m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'hB0;
      tick();
      @(negedge clk);
      chk("t6_cyc_in_rst", 32'(s_cyc_o), 0);
      chk("t6_no_term", 32'(ack0_cnt + err0_cnt + ack1_cnt + err1_cnt), 0);
      ack_at = 1;
      tick();
      rst_i = 1;
      clear_mon();
      for (int k = 0; k < 20 && grant_q.size() < 1; k++) tick();
      idle_masters();
      chk("t6_tie_winner", (grant_q.size() > 0) ? grant_q[0] : 32'hFFFF_FFFF, 32'h500);
      tick(); tick();

      // ---- slave error forwarded to m1 only ----
      do_reset();
      err_at = 1;
      m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h600;
      for (int k = 0; k < 20 && err1_cnt == 0; k++) tick();
      idle_masters();
      tick(); tick();
      chk("t7_err1_cnt", 32'(err1_cnt), 1);
      chk("t7_ack1_cnt", 32'(ack1_cnt), 0);
      chk("t7_m0_term", 32'(ack0_cnt + err0_cnt), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL give the maximum GRANT cycles before the arbiter aborts a transfer (legal range 2..256).
REQ-002 Parameter ADR_W, default 32, SHALL give the address width; data is 32 bits and select is 4 bits.
REQ-003 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-low.
REQ-005 mN_cyc_i, mN_stb_i  in  1 each (N=0,1)  master N bus request; m0 is instruction fetch, m1 is data.
REQ-006 mN_we_i  in  1  master N write enable.
REQ-007 mN_adr_i  in  ADR_W  master N address.
REQ-008 mN_dat_i  in  32  master N write data.
REQ-009 mN_sel_i  in  4  master N byte select.
REQ-010 mN_dat_o  out  32  read data, driven directly from s_dat_i to both masters.
REQ-011 mN_ack_o, mN_err_o  out  1 each  termination to master N.
REQ-012 s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side cycle, strobe and write enable.
REQ-013 s_adr_o, s_dat_o, s_sel_o  out  ADR_W/32/4  slave-side address, write data and byte select, muxed from the owner.
REQ-014 s_dat_i, s_ack_i, s_err_i  in  32/1/1  slave read data, acknowledge and error.

Function
REQ-015 The FSM SHALL use three one-hot states: IDLE=3'b001, GRANT=3'b010 and RELEASE=3'b100.
REQ-016 A master requests when mN_cyc_i and mN_stb_i are both 1.
REQ-017 IDLE: if exactly one master requests, latch it as owner; if both request, latch the master that is not last_owner; then go to GRANT on the next edge.
REQ-018 Request-to-s_cyc_o latency SHALL be exactly 1 cycle.
REQ-019 In GRANT, s_cyc_o and s_stb_o SHALL be 1, and s_we_o, s_adr_o, s_dat_o and s_sel_o SHALL follow the owner's inputs combinationally.
REQ-020 In IDLE and RELEASE, s_cyc_o and s_stb_o SHALL be 0, and the other slave outputs are don't-care.
REQ-021 s_cyc_o and s_stb_o SHALL be decoded only from registered state.
REQ-022 In GRANT, s_ack_i and s_err_i SHALL pass combinationally to the owner's ack_o/err_o in the same cycle; on either, last_owner<=owner and go to RELEASE.
REQ-023 The non-owner's ack_o and err_o SHALL be 0 at all times, and both masters' ack_o/err_o SHALL be 0 outside GRANT.
REQ-024 Kill: if the owner deasserts mN_cyc_i in GRANT, go to IDLE next edge; forward no ack/err and leave last_owner unchanged.
REQ-025 Timeout counter: clear on entry to GRANT and increment each GRANT cycle without ack/err; at count TIMEOUT-1 with no ack/err, pulse the owner's err_o for that cycle, set last_owner<=owner and go to RELEASE.
REQ-026 Ack/err and timeout in the same cycle: the slave termination SHALL be forwarded and no timeout error raised.
REQ-027 Kill and ack in the same cycle: kill SHALL win, with no ack forwarded and the next state IDLE.
REQ-028 RELEASE SHALL last exactly 1 cycle, then go to IDLE, giving a guaranteed 1-cycle s_cyc_o low gap between owners.
REQ-029 When ack/err is absent in GRANT, the FSM SHALL stay in GRANT with the owner unchanged; a new request from the other master does not preempt.
REQ-030 The timeout counter SHALL be $clog2(TIMEOUT) bits wide and SHALL never wrap inside GRANT.

Reset
REQ-031 While rst_i=0 at an edge: state<=IDLE, last_owner<=1 (so m0 wins the first tie), owner<=0, counter<=0.
REQ-032 After that edge, s_cyc_o, s_stb_o and all mN_ack_o/mN_err_o SHALL read 0.
REQ-033 Reset during GRANT SHALL abandon the transfer with no ack/err forwarded.
REQ-034 Requests held through reset SHALL be arbitrated in the first IDLE cycle after rst_i returns to 1.

Structure
REQ-035 Package wb_pkg SHALL hold the state encodings, the DAT_W=32 and SEL_W=4 constants, and the owner-index type.
REQ-036 Submodule wb_rr_arb SHALL implement the combinational two-input round-robin pick from (req0, req1, last_owner) to (valid, winner).
REQ-037 wb_arbiter SHALL hold the FSM, the owner and last_owner registers, the counter and the muxes.

Verification
REQ-038 m0 reads 0x100 and the slave acks in the 2nd GRANT cycle with 0xDEADBEEF -> s_cyc_o high 2 cycles with s_adr_o=0x100, then 1 cycle low; m0_ack_o pulses once with m0_dat_o=0xDEADBEEF; m1_ack_o stays 0.
REQ-039 Both masters request continuously from reset release with 1-cycle slave acks -> grant order m0,m1,m0,m1, each GRANT followed by 1 RELEASE cycle.
REQ-040 m1 writes 0xCAFEF00D at 0x2000 with sel 4'b0011, then drops m1_cyc_i in the 3rd GRANT cycle with no ack -> IDLE next edge, m1_ack_o and m1_err_o never 1, and the next tie goes to m0.
REQ-041 Slave never acks with TIMEOUT=16 -> m0_err_o pulses in the 16th GRANT cycle and s_cyc_o is 0 on the following cycle.
REQ-042 s_ack_i=1 exactly in the 16th GRANT cycle -> m0_ack_o=1 and m0_err_o=0.
REQ-043 rst_i driven to 0 in the 2nd GRANT cycle -> s_cyc_o=0 after that edge, no ack/err, and m0 wins the next tie.
